// File: rtl/reg_file_param.sv
// Parametrised integer register file: two combinational read ports, one write port,
// hardwired-zero x0, same-cycle write bypass and a sequential clear engine.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_CLEAR | zeroing mem[cnt] each edge; array unusable, busy high
// S_IDLE  | normal operation; reads and writes allowed
module reg_file_param #(
  parameter int XLEN = 64,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clear,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  input  logic [AW-1:0]   rd,
  input  logic            RegWrite,
  input  logic [XLEN-1:0] WriteData,
  output logic [XLEN-1:0] ReadData1,
  output logic [XLEN-1:0] ReadData2,
  output logic            busy
);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t          state, state_nxt;
  logic [AW-1:0]   cnt, cnt_nxt;
  logic [XLEN-1:0] mem [NREG];
  logic            wr_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == AW'(NREG - 1)) begin
          state_nxt = S_IDLE;
          cnt_nxt   = '0;
        end
      end
      S_IDLE: begin
        if (clear) begin
          state_nxt = S_CLEAR;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_CLEAR;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy      = (state == S_CLEAR);
  assign wr_accept = RegWrite && !busy && !clear && (rd != '0);

  // No reset on the array: the clear engine is what defines its contents.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR)
      mem[cnt] <= '0;
    else if (wr_accept)
      mem[rd] <= WriteData;
  end

  always_comb begin
    if (busy || rs1 == '0)
      ReadData1 = '0;
    else if (wr_accept && rd == rs1)
      ReadData1 = WriteData;
    else
      ReadData1 = mem[rs1];
  end

  always_comb begin
    if (busy || rs2 == '0)
      ReadData2 = '0;
    else if (wr_accept && rd == rs2)
      ReadData2 = WriteData;
    else
      ReadData2 = mem[rs2];
  end

endmodule
